fc_accumulator: RTL and testbench

- Multi-lane signed multiply-accumulate stage for the FC layers; accumulates one output neuron's dot product plus bias.
- Sits directly upstream of the FC quantizer and feeds its 32-bit signed unquantized input.
- Runs once per neuron.
- fc_state selects the FC1 or FC2 input length.

---
 rtl/fc_accumulator_if.sv | 30 +++
 rtl/fc_accumulator.sv | 105 ++++++++++
 tb/tb_fc_accumulator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fc_accumulator_if.sv
// Purpose: bundles the neuron-control, beat and result signals of the FC accumulator.
// Latency: none; this is wiring only.
// Backpressure: none; beats are qualified by in_valid and the result by acc_valid.
interface fc_accumulator_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                    fc_state;
    logic                    start;
    logic [ACC_W-1:0]        bias;
    logic                    in_valid;
    logic [LANES*DATA_W-1:0] act;
    logic [LANES*DATA_W-1:0] wgt;
    logic                    busy;
    logic                    acc_valid;
    logic [ACC_W-1:0]        acc_data;

    // The producer side drives control and beats, and observes the result.
    modport master (
        output fc_state, start, bias, in_valid, act, wgt,
        input  busy, acc_valid, acc_data
    );

    // The accumulator consumes control and beats, and drives the result.
    modport slave (
        input  fc_state, start, bias, in_valid, act, wgt,
        output busy, acc_valid, acc_data
    );
endinterface

// File: rtl/fc_accumulator.sv
// Purpose: multi-lane signed MAC that accumulates one FC neuron's dot product plus bias.
// Latency: acc_valid pulses in the cycle after the final beat is accepted (N+2 cycles minimum per neuron).
// Backpressure: none; bubbles via in_valid are unlimited, and start is ignored while busy.
module fc_accumulator #(
    parameter int LANES     = 4,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int FC1_BEATS = 200,
    parameter int FC2_BEATS = 125
) (
    input  logic               clk,
    input  logic               srstn,
    fc_accumulator_if.slave    bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int MAX_B  = (FC1_BEATS > FC2_BEATS) ? FC1_BEATS : FC2_BEATS;
    localparam int CNT_W  = $clog2(MAX_B + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [ACC_W-1:0]   bias_q;
    logic               mode_q;
    logic               busy_q;
    logic               acc_valid_q;
    logic [ACC_W-1:0]   acc_data_q;

    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [SUM_W-1:0]  lane_sum;
    logic [ACC_W-1:0]         acc_d;
    logic                     last_beat;

    // Full-width signed products (so -128*-128 survives) summed with sign extension.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]  = $signed(bus.act[i*DATA_W +: DATA_W]) * $signed(bus.wgt[i*DATA_W +: DATA_W]);
            lane_sum = lane_sum + SUM_W'(prod[i]);
        end
        acc_d     = acc_q + ACC_W'(lane_sum);
        last_beat = (beat_cnt_q == (mode_q ? CNT_W'(FC2_BEATS - 1) : CNT_W'(FC1_BEATS - 1)));
    end

    // Neuron FSM: latch mode/bias on start, accumulate beats, emit the biased sum once.
    // The result register is loaded on the edge that enters OUT so acc_data is
    // already valid during the single acc_valid cycle.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            bias_q      <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_valid_q <= 1'b0;
                    if (bus.start) begin
                        bias_q     <= bus.bias;
                        mode_q     <= bus.fc_state;
                        acc_q      <= '0;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc_q      <= acc_d;
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            acc_data_q  <= acc_d + bias_q;
                            acc_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end
                    end
                end
                OUT: begin
                    acc_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    acc_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_data  = acc_data_q;
endmodule

// File: tb/tb_fc_accumulator.sv
// Purpose: randomized scoreboard bench for fc_accumulator against a dot-product reference.
// Latency: checks the one-cycle-after-last-beat result pulse and the 202-cycle back-to-back gap.
// Backpressure: exercises in_valid bubbles and starts issued while busy.
module tb_fc_accumulator;
    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    logic clk   = 1'b0;
    logic srstn = 1'b0;
    always #5 clk = ~clk;

    fc_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    fc_accumulator #(
        .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W),
        .FC1_BEATS(200), .FC2_BEATS(125)
    ) dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] exp_q [$];
    int          vt_q  [$];
    logic [31:0] e_mon;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (srstn === 1'b1 && bus.acc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_acc_valid", 64'd1, 64'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("acc_data", 64'(bus.acc_data), 64'(e_mon));
            end
            vt_q.push_back(cyc);
        end
    end

    function automatic logic [31:0] gen(input int pat, input bit is_act);
        case (pat)
            0:       return 32'h0101_0101;
            1:       return is_act ? 32'h0000_0003 : 32'h0000_00FE;
            2:       return 32'h8080_8080;
            default: return $urandom;
        endcase
    endfunction

    // Runs one neuron starting in the current cycle; returns in the IDLE cycle after OUT.
    // abort_at >= 0 pulses reset while that beat index is on the bus.
    task automatic run_neuron(input bit mode, input logic signed [31:0] b, input int pat,
                              input int bubble_pct, input bit disturb, input int abort_at);
        int                 n;
        int                 i;
        logic [31:0]        ab [200];
        logic [31:0]        wb [200];
        longint             s;
        logic signed [7:0]  a;
        logic signed [7:0]  w;
        n = mode ? 125 : 200;
        s = longint'(b);
        for (int k = 0; k < n; k++) begin
            ab[k] = gen(pat, 1'b1);
            wb[k] = gen(pat, 1'b0);
            for (int l = 0; l < LANES; l++) begin
                a = ab[k][l*8 +: 8];
                w = wb[k][l*8 +: 8];
                s = s + longint'(a) * longint'(w);
            end
        end
        if (abort_at < 0) exp_q.push_back(s[31:0]);

        bus.start    = 1'b1;
        bus.fc_state = mode;
        bus.bias     = b;
        bus.in_valid = (pat == 3);
        bus.act      = $urandom;
        bus.wgt      = $urandom;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);

        i = 0;
        while (i < n) begin
            if (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
                bus.in_valid = 1'b0;
                bus.act      = $urandom;
                bus.wgt      = $urandom;
            end else begin
                bus.in_valid = 1'b1;
                bus.act      = ab[i];
                bus.wgt      = wb[i];
                i++;
            end
            if (disturb) begin
                bus.start    = 1'($urandom_range(1));
                bus.fc_state = ~mode;
                bus.bias     = $urandom;
            end
            if (abort_at >= 0 && i == abort_at + 1 && bus.in_valid) begin
                #2 srstn = 1'b0;
                #1;
                chk("abort_busy", 64'(bus.busy), 64'd0);
                chk("abort_acc_data", 64'(bus.acc_data), 64'd0);
                chk("abort_acc_valid", 64'(bus.acc_valid), 64'd0);
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                #2 srstn = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            if (i < n) chk("no_early_valid", 64'(bus.acc_valid), 64'd0);
        end

        // OUT cycle: beats and start here must be ignored.
        bus.in_valid = (pat == 3);
        bus.act      = $urandom;
        bus.wgt      = $urandom;
        bus.start    = disturb;
        chk("acc_valid_latency", 64'(bus.acc_valid), 64'd1);
        chk("busy_in_out", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("acc_valid_pulse_width", 64'(bus.acc_valid), 64'd0);
        chk("busy_drop", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.fc_state = 1'b0;
        bus.start    = 1'b0;
        bus.bias     = '0;
        bus.in_valid = 1'b0;
        bus.act      = '0;
        bus.wgt      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_acc_valid", 64'(bus.acc_valid), 64'd0);
        chk("reset_acc_data", 64'(bus.acc_data), 64'd0);
        srstn = 1'b1;

        // Start in the first active cycle after reset.
        run_neuron(1'b0, 32'sd0, 0, 0, 1'b0, -1);          // FC1 ones -> 800
        run_neuron(1'b1, -32'sd100, 1, 0, 1'b0, -1);       // FC2 lane0 3*-2 -> -850
        run_neuron(1'b0, 32'sd5, 2, 0, 1'b0, -1);          // FC1 -128*-128 -> 13107205
        run_neuron(1'b0, 32'sh7FFF_FF00, 0, 0, 1'b0, -1);  // wraps modulo 2^32
        run_neuron(1'b1, $urandom, 3, 50, 1'b1, -1);       // bubbles + mid-neuron disturbance
        run_neuron(1'b1, $urandom, 3, 50, 1'b1, -1);
        run_neuron(1'b0, $urandom, 3, 30, 1'b1, -1);

        repeat (3) @(posedge clk);
        #1;
        run_neuron(1'b0, 32'sd1234, 3, 0, 1'b0, 60);       // reset during beat 60
        repeat (3) @(posedge clk);
        #1;
        run_neuron(1'b0, $urandom, 3, 20, 1'b0, -1);       // fresh result after abort

        n0 = vt_q.size();
        run_neuron(1'b0, $urandom, 3, 0, 1'b0, -1);
        run_neuron(1'b0, $urandom, 3, 0, 1'b0, -1);
        chk("b2b_pulse_count", 64'(vt_q.size()), 64'(n0 + 2));
        if (vt_q.size() >= 2)
            chk("b2b_gap", 64'(vt_q[vt_q.size()-1] - vt_q[vt_q.size()-2]), 64'd202);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_expected", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
